// File: rtl/adder_result_stage.sv
// adder_result_stage
//   Captures results from an upstream N-bit adder into a 2-entry FIFO
//   together with the Z/N/C/V flags computed at capture time, and keeps a
//   saturating count of captured results that overflowed (signed).
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   a, b               adder operands (only their MSBs feed the V flag)
//   s, cout            adder sum and carry-out
//   in_valid/in_ready  upstream handshake; in_ready = (count < 2)
//   res, flag_z/n/c/v  head entry of the FIFO
//   out_valid/out_ready downstream handshake; out_valid = (count > 0)
//   clr_cnt            synchronous clear of ov_cnt (wins over increment)
//   ov_cnt             saturating count of captured results with V=1
module adder_result_stage #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] s,
  input  logic         cout,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] res,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_c,
  output logic         flag_v,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         clr_cnt,
  output logic [7:0]   ov_cnt
);

  // Entry layout: {sum, Z, N, C, V}
  localparam int unsigned W = N + 4;

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  logic         push;
  logic         pop;
  logic         z_in;
  logic         n_in;
  logic         v_in;
  logic [W-1:0] entry;
  logic [W-1:0] head;

  // Readiness derives from registered count only, so a full FIFO never
  // accepts a refill in the same cycle it is popped.
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    z_in  = (s == '0);
    n_in  = s[N-1];
    v_in  = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
    entry = {s, z_in, n_in, cout, v_in};
  end

  // Storage is reset so the outputs read zero (never X) while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_cnt <= '0;
    end else if (clr_cnt) begin
      ov_cnt <= '0;
    end else if (push && v_in && (ov_cnt != '1)) begin
      ov_cnt <= ov_cnt + 8'd1;
    end
  end

  always_comb begin
    head   = mem[rd_ptr];
    res    = head[W-1:4];
    flag_z = head[3];
    flag_n = head[2];
    flag_c = head[1];
    flag_v = head[0];
  end

endmodule

// File: tb/tb_adder_result_stage.sv
module tb_adder_result_stage;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] s;
  logic         cout;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] res;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  logic         out_valid;
  logic         out_ready;
  logic         clr_cnt;
  logic [7:0]   ov_cnt;

  int n_chk;
  int n_bad;

  adder_result_stage #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .s         (s),
    .cout      (cout),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res       (res),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr_cnt   (clr_cnt),
    .ov_cnt    (ov_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ta, input logic [3:0] tb_, input logic [3:0] ts,
                       input logic tc);
    a    = ta;
    b    = tb_;
    s    = ts;
    cout = tc;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0; clr_cnt = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1;
    drive(4'b0111, 4'b0011, 4'b1010, 1'b1);

    // Reset held with in_valid high: nothing captured.
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ov_cnt", ov_cnt, 0);
    chk("rst_res", res, 0);
    chk("rst_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", out_valid, 0);

    // 1010 + 0101 = 1111, no carry
    drive(4'b1010, 4'b0101, 4'b1111, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("v1_out_valid", out_valid, 1);
    chk("v1_res", res, 4'hf);
    chk("v1_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0100);
    chk("v1_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("v1_drain", out_valid, 0);

    // 1111 + 0001 = 0000 carry 1
    drive(4'b1111, 4'b0001, 4'b0000, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("v2_res", res, 4'h0);
    chk("v2_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1010);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 0111 + 0011 = 1010: signed overflow
    drive(4'b0111, 4'b0011, 4'b1010, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("v3_res", res, 4'ha);
    chk("v3_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0101);
    chk("v3_ov_cnt", ov_cnt, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("v3_drain", out_valid, 0);

    // Fill with out_ready low; third result held upstream.
    in_valid = 1'b1;
    drive(4'h1, 4'h0, 4'h1, 1'b0);
    step();
    chk("fill1_in_ready", in_ready, 1);
    drive(4'h2, 4'h0, 4'h2, 1'b0);
    step();
    chk("fill2_in_ready", in_ready, 0);
    drive(4'h3, 4'h0, 4'h3, 1'b0);
    step();
    chk("full_in_ready", in_ready, 0);
    chk("full_head", res, 1);
    out_ready = 1'b1;
    step();
    chk("drain1_res", res, 2);
    chk("drain1_valid", out_valid, 1);
    chk("drain1_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("drain2_res", res, 3);
    chk("drain2_valid", out_valid, 1);
    step();
    chk("drain3_empty", out_valid, 0);
    chk("fill_ov_cnt", ov_cnt, 1);

    // Streaming at count=1: res follows input one cycle later.
    out_ready = 1'b0;
    drive(4'h0, 4'h0, 4'h0, 1'b0);
    in_valid = 1'b1;
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(i[3:0], 4'h0, i[3:0], 1'b0);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_res", res, i[3:0]);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", out_valid, 0);
    chk("stream_ov_cnt", ov_cnt, 1);

    // Clear, then saturate ov_cnt.
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_ov_cnt", ov_cnt, 0);
    drive(4'b0111, 4'b0011, 4'b1010, 1'b0);
    in_valid = 1'b1;
    for (int i = 1; i <= 254; i++) step();
    chk("sat_254", ov_cnt, 254);
    step();
    chk("sat_255", ov_cnt, 255);
    step();
    chk("sat_hold", ov_cnt, 255);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    in_valid = 1'b0;
    chk("clr_prio", ov_cnt, 0);
    chk("clr_push_valid", out_valid, 1);
    step();
    chk("clr_drain", out_valid, 0);

    // Reset while full discards both entries.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(4'h5, 4'h0, 4'h5, 1'b0);
    step();
    drive(4'h6, 4'h0, 4'h6, 1'b0);
    step();
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 1);
    chk("async_rst_res", res, 0);
    step();
    rst_n = 1'b1;
    drive(4'h9, 4'h0, 4'h9, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("after_rst_res", res, 9);
    chk("after_rst_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("after_rst_alone", out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_result_stage.md
ADDER_RESULT_STAGE -- requirements
Module: adder_result_stage

Interface
REQ-001 Parameter N, default 4, operand/sum width in bits; N >= 2 SHALL be supported.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 a  input  N  adder operand A, used for the overflow flag.
REQ-005 b  input  N  adder operand B, used for the overflow flag.
REQ-006 s  input  N  sum output of the upstream nbit_adder.
REQ-007 cout  input  1  carry-out of the upstream nbit_adder.
REQ-008 in_valid  input  1  a/b/s/cout hold a result to capture.
REQ-009 in_ready  output  1  stage can accept a result this cycle.
REQ-010 res  output  N  sum of the head entry.
REQ-011 flag_z, flag_n, flag_c, flag_v  output  1 each  zero, negative, carry and signed-overflow flags of the head entry.
REQ-012 out_valid  output  1  head entry is valid.
REQ-013 out_ready  input  1  downstream consumes the head entry.
REQ-014 clr_cnt  input  1  synchronous clear of ov_cnt.
REQ-015 ov_cnt  output  8  saturating count of accepted results with V=1.

Function
REQ-016 Storage SHALL be a 2-entry FIFO of {s, Z, N, C, V}, with 1-bit write pointer, 1-bit read pointer and a 2-bit occupancy count (0..2).
REQ-017 Flags SHALL be computed at capture: Z = (s == 0); N = s[N-1]; C = cout; V = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]).
REQ-018 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL equal (count < 2), combinationally from registered state only.
REQ-020 out_valid SHALL equal (count > 0); res and the flags SHALL always reflect the entry at the read pointer.
REQ-021 Latency: a result pushed at edge k SHALL appear on the outputs after edge k when the FIFO was empty.
REQ-022 Push and pop at the same edge with count 1 SHALL leave count at 1, and the new entry SHALL become head.
REQ-023 Push and pop at the same edge with count 0 is impossible by REQ-020; no bypass path SHALL exist.
REQ-024 When count is 2, in_valid SHALL be ignored even if out_ready is high that cycle (no same-cycle refill when full).
REQ-025 out_ready while empty SHALL have no effect; pointers SHALL wrap modulo 2.
REQ-026 FIFO order SHALL be preserved; no entry SHALL be dropped or duplicated.
REQ-027 ov_cnt SHALL increment on each push with V=1 and saturate at 255.
REQ-028 clr_cnt SHALL take priority over a same-cycle increment, giving ov_cnt = 0.
REQ-029 res and the flags when out_valid=0 are don't-care for checking, but SHALL be free of X after reset.

Reset
REQ-030 rst_n=0 SHALL immediately force count=0, both pointers=0, ov_cnt=0, out_valid=0, in_ready=1, and res and all flags = 0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; the first push after release SHALL be delivered first.
REQ-032 The first edge after rst_n rises SHALL be able to accept a push.

Verification
REQ-033 Reset with in_valid=1 held -> out_valid=0, in_ready=1, ov_cnt=0 during reset; no capture occurs.
REQ-034 N=4: a=1010, b=0101, s=1111, cout=0 pushed -> next cycle res=1111, Z=0, N=1, C=0, V=0, out_valid=1.
REQ-035 a=1111, b=0001, s=0000, cout=1 -> Z=1, N=0, C=1, V=0; then a=0111, b=0011, s=1010, cout=0 -> V=1, N=1, ov_cnt=1.
REQ-036 out_ready=0, push three results with in_valid held -> in_ready=0 after two; the third is held upstream; then out_ready=1 -> entries emerge in order, the third is accepted, and there are no gaps or duplicates.
REQ-037 count=1 with simultaneous push/pop each cycle for 10 cycles -> out_valid stays 1 and res follows the input stream one cycle delayed.
REQ-038 Load ov_cnt=255 via 255 V=1 pushes, push again -> ov_cnt stays 255; clr_cnt with a V=1 push -> 0; reset with count=2 -> empty, and the next push appears alone.
